// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode values, FSM encoding and the default datapath width.
// Holds no logic, so it adds no latency and applies no backpressure.
package alu_arbiter_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SLL  = 3'd1,
        OP_SLT  = 3'd2,
        OP_SLTU = 3'd3,
        OP_XOR  = 3'd4,
        OP_SR   = 3'd5,
        OP_OR   = 3'd6,
        OP_AND  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first set req bit at or above ptr, wrapping at N.
// Purely combinational (zero latency); applies no backpressure of its own.
module alu_arbiter_rr_pick
    import alu_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among N requesters; result valid two edges after grant, at most one op outstanding.
// Backpressure: no grant while a response is unaccepted; ALU inputs held so the result stays stable meanwhile.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*3-1:0] req_op,
    input  logic [N-1:0]   req_mod,
    output logic [N-1:0]   rsp_valid,
    input  logic [N-1:0]   rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [2:0]     alu_op,
    output logic           alu_mod,
    input  logic [W-1:0]   alu_res,
    output logic           busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic          alu_mod_q, alu_mod_d;

    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_idx;
    logic [W-1:0]  sel_a, sel_b;
    logic [2:0]    sel_op;
    logic          sel_mod;
    logic          can_issue, issue;

    alu_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        sel_mod = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_op  = req_op[i*3 +: 3];
                sel_mod = req_mod[i];
            end
        end
    end

    // Issuing is allowed from IDLE or in the same cycle the owner takes its result.
    always_comb begin
        can_issue = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready[owner_q]);
        req_ready = can_issue ? gnt : '0;
        issue     = |req_ready;

        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_mod_d = alu_mod_q;

        case (state_q)
            ST_IDLE: if (issue) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready[owner_q]) state_d = issue ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_op_d  = sel_op;
            alu_mod_d = sel_mod;
            owner_d   = gnt_idx;
            rr_ptr_d  = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i] = (state_q == ST_RESP) && (owner_q == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_mod_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_mod_q <= alu_mod_d;
        end
    end

    assign rsp_data = alu_res;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_mod  = alu_mod_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with N=2, driving a registered ALU model from the arbiter's alu_* outputs.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk, rst_n;
    logic [1:0]  req_valid, req_ready, req_mod, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [31:0] rsp_data, alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        alu_mod, busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.N(2), .W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_mod   (req_mod),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_mod   (alu_mod),
        .alu_res   (alu_res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: mod selects SUB for ADD and arithmetic shift for SR.
    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic m,
                                          input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return m ? a - b : a + b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SR:   return m ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            OP_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) alu_res <= alu_f(alu_op, alu_mod, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic m,
                           input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_op[i*3 +: 3]  = op;
        req_mod[i]        = m;
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0; req_mod = '0;
        nc(); nc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;

        // Single request: ADD 5+7
        nc(); set_req(0, OP_ADD, 1'b0, 32'd5, 32'd7); req_valid = 2'b01; rsp_ready = 2'b11; #1;
        chk("t1_grant", req_ready, 2'b01);
        chk("t1_idle_busy", busy, 0);
        nc(); req_valid = 2'b00; #1;
        chk("t1_exec_busy", busy, 1);
        chk("t1_exec_rsp", rsp_valid, 2'b00);
        chk("t1_alu_a", alu_a, 32'd5);
        nc(); #1;
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data, 32'd12);
        nc(); #1;
        chk("t1_done_busy", busy, 0);
        chk("t1_done_rsp", rsp_valid, 2'b00);

        // Stalled response: arithmetic shift right, req0 pending
        nc(); set_req(1, OP_SR, 1'b1, 32'h8000_0000, 32'd4); req_valid = 2'b10; rsp_ready = 2'b00; #1;
        chk("t2_grant", req_ready, 2'b10);
        nc(); set_req(0, OP_ADD, 1'b0, 32'd1, 32'd2); req_valid = 2'b01; #1;
        chk("t2_exec_ready", req_ready, 2'b00);
        for (int k = 0; k < 5; k++) begin
            nc(); #1;
            chk("t2_stall_valid", rsp_valid, 2'b10);
            chk("t2_stall_data", rsp_data, 32'hF800_0000);
            chk("t2_stall_ready", req_ready, 2'b00);
        end
        nc(); rsp_ready = 2'b10; #1;
        chk("t2_accept_valid", rsp_valid, 2'b10);
        chk("t2_accept_grant", req_ready, 2'b01);
        nc(); req_valid = 2'b00; rsp_ready = 2'b11; #1;
        chk("t2_exec_rsp", rsp_valid, 2'b00);
        chk("t2_exec_busy", busy, 1);
        nc(); #1;
        chk("t2_req0_valid", rsp_valid, 2'b01);
        chk("t2_req0_data", rsp_data, 32'd3);
        nc(); #1;
        chk("t2_idle", busy, 0);

        // Round-robin from a fresh pointer
        nc(); rst_n = 1'b0;
        nc(); rst_n = 1'b1;
        nc();
        set_req(0, OP_XOR, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF);
        set_req(1, OP_OR,  1'b0, 32'h1200_0034, 32'h0045_6700);
        req_valid = 2'b11; rsp_ready = 2'b11; #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_rsp_data", rsp_data, (k % 2 == 1) ? 32'hFF00_12CB : 32'h1245_6734);
            end
            nc(); #1;
            chk("rr_exec_ready", req_ready, 2'b00);
            nc(); if (k == 7) req_valid = 2'b00; #1;
        end
        chk("rr_last_valid", rsp_valid, 2'b10);
        chk("rr_last_data", rsp_data, 32'h1245_6734);

        // Signed vs unsigned compare, back-to-back
        nc(); set_req(0, OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1); req_valid = 2'b01; #1;
        chk("t4_grant", req_ready, 2'b01);
        nc(); set_req(0, OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1); #1;
        chk("t4_exec_ready", req_ready, 2'b00);
        nc(); #1;
        chk("t4_slt_valid", rsp_valid, 2'b01);
        chk("t4_slt_data", rsp_data, 32'd1);
        chk("t4_b2b_grant", req_ready, 2'b01);
        nc(); req_valid = 2'b00; #1;
        chk("t4_exec_rsp", rsp_valid, 2'b00);
        nc(); #1;
        chk("t4_sltu_valid", rsp_valid, 2'b01);
        chk("t4_sltu_data", rsp_data, 32'd0);

        // Reset during EXEC
        nc(); set_req(0, OP_XOR, 1'b0, 32'd10, 32'd3); req_valid = 2'b01; #1;
        chk("t5_grant", req_ready, 2'b01);
        nc(); req_valid = 2'b00; rst_n = 1'b0; #1;
        chk("t5_exec_busy", busy, 1);
        nc(); #1;
        chk("t5_rst_rsp", rsp_valid, 2'b00);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_alu_op", alu_op, 3'd0);
        chk("t5_rst_alu_a", alu_a, 32'd0);
        rst_n = 1'b1; set_req(1, OP_ADD, 1'b0, 32'd1, 32'd1); req_valid = 2'b11; rsp_ready = 2'b00; #1;
        chk("t5_ptr_reset", req_ready, 2'b01);

        // Reset during RESP
        nc(); req_valid = 2'b10; #1;
        nc(); #1;
        chk("t5b_rsp_valid", rsp_valid, 2'b01);
        chk("t5b_rsp_data", rsp_data, 32'd9);
        rst_n = 1'b0; req_valid = 2'b00;
        nc(); #1;
        chk("t5b_rst_rsp", rsp_valid, 2'b00);
        chk("t5b_rst_busy", busy, 0);
        chk("t5b_rst_alu_op", alu_op, 3'd0);
        chk("t5b_rst_alu_a", alu_a, 32'd0);
        rst_n = 1'b1; req_valid = 2'b11; #1;
        chk("t5b_ptr_reset", req_ready, 2'b01);

        // Wrong-owner ready is ignored
        nc(); req_valid = 2'b10; #1;
        chk("t6_exec_ready", req_ready, 2'b00);
        nc(); rsp_ready = 2'b10; #1;
        chk("t6_rsp_valid", rsp_valid, 2'b01);
        chk("t6_rsp_data", rsp_data, 32'd9);
        chk("t6_no_grant", req_ready, 2'b00);
        nc(); #1;
        chk("t6_hold_valid", rsp_valid, 2'b01);
        chk("t6_hold_busy", busy, 1);
        chk("t6_hold_no_grant", req_ready, 2'b00);
        nc(); rsp_ready = 2'b01; #1;
        chk("t6_accept_grant", req_ready, 2'b10);
        nc(); req_valid = 2'b00; rsp_ready = 2'b11; #1;
        chk("t6_exec_rsp", rsp_valid, 2'b00);
        nc(); #1;
        chk("t6_req1_valid", rsp_valid, 2'b10);
        chk("t6_req1_data", rsp_data, 32'd2);
        nc(); #1;
        chk("t6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
